// File: rtl/tri_sched_pkg.sv
// Shared parameter defaults and scheduler state encoding for the triangle
// scheduler and its rasteriser-side consumers.
package rast_params;

  localparam int SIGFIG_D       = 24;
  localparam int RADIX_D        = 10;
  localparam int VERTS_D        = 3;
  localparam int AXIS_D         = 3;
  localparam int COLORS_D       = 3;
  localparam int DRAIN_CYCLES_D = 16;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    APPLY = 2'd2
  } sched_state_e;

endpackage

// File: rtl/tri_sched_if.sv
// Two-requester triangle offer bus: per-requester valid/ready plus triangle
// and colour payloads.
interface tri_sched_if
  import rast_params::*;
#(
  parameter int SIGFIG = SIGFIG_D,
  parameter int VERTS  = VERTS_D,
  parameter int AXIS   = AXIS_D,
  parameter int COLORS = COLORS_D
);
  logic [1:0]                                   req_valid_H;
  logic [1:0]                                   req_ready_H;
  logic [1:0][VERTS-1:0][AXIS-1:0][SIGFIG-1:0]  req_tri_S;
  logic [1:0][COLORS-1:0][SIGFIG-1:0]           req_color_U;

  modport master (
    output req_valid_H, req_tri_S, req_color_U,
    input  req_ready_H
  );

  modport slave (
    input  req_valid_H, req_tri_S, req_color_U,
    output req_ready_H
  );
endinterface

// File: rtl/tri_sched_rr_arb2.sv
// Two-way round-robin arbiter; the pointer remembers the last winner and only
// moves when a grant is actually issued.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_en,
  output logic [1:0] o_gnt
);
  logic r_last;

  always_comb begin
    o_gnt = '0;
    if (i_en) begin
      case (i_req)
        2'b01:   o_gnt = 2'b01;
        2'b10:   o_gnt = 2'b10;
        2'b11:   o_gnt = r_last ? 2'b01 : 2'b10;
        default: o_gnt = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= 1'b1;
    end else if (|o_gnt) begin
      r_last <= o_gnt[1];
    end
  end
endmodule

// File: rtl/tri_sched.sv
// Triangle scheduler: merges two requesters into a single registered rasteriser
// slot and applies screen/subsample changes only after the pipe has drained.
module tri_sched
  import rast_params::*;
#(
  parameter int SIGFIG       = SIGFIG_D,
  parameter int RADIX        = RADIX_D,
  parameter int VERTS        = VERTS_D,
  parameter int AXIS         = AXIS_D,
  parameter int COLORS       = COLORS_D,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_D
) (
  input  logic                                 clk,
  input  logic                                 rst,
  tri_sched_if.slave                           req_if,
  input  logic                                 cfg_valid_H,
  output logic                                 cfg_ready_H,
  input  logic [1:0][SIGFIG-1:0]               cfg_screen_S,
  input  logic [3:0]                           cfg_subSample_U,
  output logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R10S,
  output logic [COLORS-1:0][SIGFIG-1:0]        color_R10U,
  output logic                                 validTri_R10H,
  input  logic                                 halt_RnnnnL,
  output logic [1:0][SIGFIG-1:0]               screen_RnnnnS,
  output logic [3:0]                           subSample_RnnnnU
);
  localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);

  if (DRAIN_CYCLES < 1 || RADIX > SIGFIG) begin : g_param_check
    $error("tri_sched: DRAIN_CYCLES must be >= 1 and RADIX <= SIGFIG");
  end

  sched_state_e                          r_state, w_state_nxt;
  logic [CNT_W-1:0]                      r_drain_cnt;
  logic                                  r_valid;
  logic                                  r_cfg_ready;
  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] r_tri;
  logic [COLORS-1:0][SIGFIG-1:0]         r_color;
  logic [1:0][SIGFIG-1:0]                r_screen;
  logic [3:0]                            r_subsample;
  logic                                  w_accept;
  logic                                  w_slot_free;
  logic                                  w_grant_en;
  logic                                  w_drain_done;
  logic                                  w_sel;
  logic [1:0]                            w_gnt;

  assign w_accept     = r_valid & halt_RnnnnL;
  assign w_slot_free  = ~r_valid | halt_RnnnnL;
  assign w_drain_done = (r_drain_cnt == CNT_W'(DRAIN_CYCLES));
  assign w_sel        = w_gnt[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_en  = 1'b0;
    unique case (r_state)
      RUN: begin
        if (cfg_valid_H) begin
          w_state_nxt = DRAIN;
        end else begin
          w_grant_en = w_slot_free & ~rst;
        end
      end
      DRAIN:   if (w_drain_done) w_state_nxt = APPLY;
      APPLY:   w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .i_req (req_if.req_valid_H),
    .i_en  (w_grant_en),
    .o_gnt (w_gnt)
  );

  assign req_if.req_ready_H = w_gnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_tri   <= '0;
      r_color <= '0;
    end else if (|w_gnt) begin
      r_valid <= 1'b1;
      r_tri   <= req_if.req_tri_S[w_sel];
      r_color <= req_if.req_color_U[w_sel];
    end else if (w_accept) begin
      r_valid <= 1'b0;
    end
  end

  // Counts consecutive idle-and-ready cycles; anything else restarts the count.
  always_ff @(posedge clk) begin
    if (rst || r_state != DRAIN) begin
      r_drain_cnt <= '0;
    end else if (!r_valid && halt_RnnnnL) begin
      if (!w_drain_done) r_drain_cnt <= r_drain_cnt + 1'b1;
    end else begin
      r_drain_cnt <= '0;
    end
  end

  // Config loads on the edge entering APPLY so the pulse and new values coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cfg_ready <= 1'b0;
      r_screen    <= '0;
      r_subsample <= '0;
    end else begin
      r_cfg_ready <= (w_state_nxt == APPLY);
      if (w_state_nxt == APPLY) begin
        r_screen    <= cfg_screen_S;
        r_subsample <= cfg_subSample_U;
      end
    end
  end

  assign validTri_R10H    = r_valid;
  assign tri_R10S         = r_tri;
  assign color_R10U       = r_color;
  assign cfg_ready_H      = r_cfg_ready;
  assign screen_RnnnnS    = r_screen;
  assign subSample_RnnnnU = r_subsample;
endmodule

// File: tb/tb_tri_sched.sv
// Bench for tri_sched: vector table, directed drain/stall/reset sequences and
// randomized traffic against a cycle-level behavioural model.
module tb_tri_sched;
  localparam int SIGFIG = 24;
  localparam int VERTS  = 3;
  localparam int AXIS   = 3;
  localparam int COLORS = 3;
  localparam int DC     = 16;
  localparam int TW     = VERTS * AXIS * SIGFIG;
  localparam int CLW    = COLORS * SIGFIG;
  localparam int M_RUN = 0, M_DRAIN = 1, M_APPLY = 2;

  logic clk, rst;
  logic cfg_valid_H, cfg_ready_H;
  logic [1:0][SIGFIG-1:0] cfg_screen_S, screen_RnnnnS;
  logic [3:0] cfg_subSample_U, subSample_RnnnnU;
  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R10S;
  logic [COLORS-1:0][SIGFIG-1:0] color_R10U;
  logic validTri_R10H, halt_RnnnnL;

  tri_sched_if #(.SIGFIG(SIGFIG), .VERTS(VERTS), .AXIS(AXIS), .COLORS(COLORS)) rif ();

  tri_sched #(
    .SIGFIG(SIGFIG), .RADIX(10), .VERTS(VERTS), .AXIS(AXIS),
    .COLORS(COLORS), .DRAIN_CYCLES(DC)
  ) dut (
    .clk(clk), .rst(rst), .req_if(rif),
    .cfg_valid_H(cfg_valid_H), .cfg_ready_H(cfg_ready_H),
    .cfg_screen_S(cfg_screen_S), .cfg_subSample_U(cfg_subSample_U),
    .tri_R10S(tri_R10S), .color_R10U(color_R10U), .validTri_R10H(validTri_R10H),
    .halt_RnnnnL(halt_RnnnnL), .screen_RnnnnS(screen_RnnnnS),
    .subSample_RnnnnU(subSample_RnnnnU)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: output slot contents, last winner, and a drain/apply phase with an idle streak.
  bit m_valid, m_last, m_cfgrdy;
  int m_mode, m_idle;
  logic [TW-1:0] m_tri;
  logic [CLW-1:0] m_col;
  logic [2*SIGFIG-1:0] m_scr;
  logic [3:0] m_sub;

  typedef struct {
    logic [1:0] rv;
    logic       halt;
    logic [1:0] exp_rdy;
    logic       exp_v;
    int         exp_idx;
    int         exp_req;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [TW-1:0] mk_tri(input int idx, input int r);
    logic [TW-1:0] t;
    for (int k = 0; k < VERTS * AXIS; k++)
      t[k*SIGFIG +: SIGFIG] = SIGFIG'((idx << 12) | (r << 8) | k | 32'h40_0000);
    return t;
  endfunction

  function automatic logic [CLW-1:0] mk_col(input int idx, input int r);
    logic [CLW-1:0] c;
    for (int k = 0; k < COLORS; k++)
      c[k*SIGFIG +: SIGFIG] = SIGFIG'((idx << 12) | (r << 8) | k | 32'h80);
    return c;
  endfunction

  task automatic set_data(input int idx);
    for (int r = 0; r < 2; r++) begin
      rif.req_tri_S[r]   = mk_tri(idx, r);
      rif.req_color_U[r] = mk_col(idx, r);
    end
  endtask

  function automatic logic [1:0] model_grant();
    logic [1:0] v;
    v = rif.req_valid_H;
    if (rst || m_mode != M_RUN || cfg_valid_H || (m_valid && !halt_RnnnnL)) return 2'b00;
    if (v == 2'b11) return m_last ? 2'b01 : 2'b10;
    return v;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_last = 1; m_cfgrdy = 0; m_mode = M_RUN; m_idle = 0;
    m_tri = '0; m_col = '0; m_scr = '0; m_sub = '0;
  endtask

  task automatic model_update(input logic [1:0] g);
    bit was_valid;
    if (rst) begin
      model_reset();
    end else begin
      was_valid = m_valid;
      m_cfgrdy = 0;
      if (g != 2'b00) begin
        m_valid = 1;
        m_last  = g[1];
        m_tri   = rif.req_tri_S[g[1]];
        m_col   = rif.req_color_U[g[1]];
      end else if (m_valid && halt_RnnnnL) begin
        m_valid = 0;
      end
      case (m_mode)
        M_RUN: if (cfg_valid_H) begin m_mode = M_DRAIN; m_idle = 0; end
        M_DRAIN: begin
          if (m_idle >= DC) begin
            m_mode = M_APPLY; m_cfgrdy = 1; m_scr = cfg_screen_S; m_sub = cfg_subSample_U;
          end else if (!was_valid && halt_RnnnnL) m_idle++;
          else m_idle = 0;
        end
        default: m_mode = M_RUN;
      endcase
    end
  endtask

  task automatic tick();
    logic [1:0] g;
    #1;
    g = model_grant();
    chk("req_ready", 256'(rif.req_ready_H), 256'(g));
    @(posedge clk);
    model_update(g);
    #1;
    chk("validTri", 256'(validTri_R10H), 256'(m_valid));
    if (m_valid) begin
      chk("tri", 256'(tri_R10S), 256'(m_tri));
      chk("color", 256'(color_R10U), 256'(m_col));
    end
    chk("cfg_ready", 256'(cfg_ready_H), 256'(m_cfgrdy));
    chk("screen", 256'(screen_RnnnnS), 256'(m_scr));
    chk("subSample", 256'(subSample_RnnnnU), 256'(m_sub));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k, hold;
    bit seen;
    tbl[0]  = '{2'b01, 1'b1, 2'b01, 1'b0, 0, 0};
    tbl[1]  = '{2'b11, 1'b1, 2'b10, 1'b1, 0, 0};
    tbl[2]  = '{2'b11, 1'b1, 2'b01, 1'b1, 1, 1};
    tbl[3]  = '{2'b11, 1'b0, 2'b00, 1'b1, 2, 0};
    tbl[4]  = '{2'b11, 1'b0, 2'b00, 1'b1, 2, 0};
    tbl[5]  = '{2'b11, 1'b1, 2'b10, 1'b1, 2, 0};
    tbl[6]  = '{2'b00, 1'b1, 2'b00, 1'b1, 5, 1};
    tbl[7]  = '{2'b10, 1'b0, 2'b10, 1'b0, 0, 0};
    tbl[8]  = '{2'b11, 1'b1, 2'b01, 1'b1, 7, 1};
    tbl[9]  = '{2'b00, 1'b0, 2'b00, 1'b1, 8, 0};
    tbl[10] = '{2'b00, 1'b1, 2'b00, 1'b1, 8, 0};
    tbl[11] = '{2'b00, 1'b1, 2'b00, 1'b0, 0, 0};

    rst = 1; cfg_valid_H = 0; halt_RnnnnL = 1;
    cfg_screen_S = '0; cfg_subSample_U = '0;
    rif.req_valid_H = 2'b11; set_data(99);
    model_reset();
    tick();
    #1 chk("rst_ready", 256'(rif.req_ready_H), 256'(0));
    tick();
    chk("rst_valid", 256'(validTri_R10H), 256'(0));
    chk("rst_tri", 256'(tri_R10S), 256'(0));
    chk("rst_color", 256'(color_R10U), 256'(0));
    chk("rst_cfg_ready", 256'(cfg_ready_H), 256'(0));
    chk("rst_screen", 256'(screen_RnnnnS), 256'(0));
    chk("rst_sub", 256'(subSample_RnnnnU), 256'(0));
    rst = 0;

    // Arbitration / stall vector table
    for (int i = 0; i < 12; i++) begin
      rif.req_valid_H = tbl[i].rv; halt_RnnnnL = tbl[i].halt; set_data(i);
      #1;
      chk("tbl_ready", 256'(rif.req_ready_H), 256'(tbl[i].exp_rdy));
      chk("tbl_valid", 256'(validTri_R10H), 256'(tbl[i].exp_v));
      if (tbl[i].exp_v) chk("tbl_tri", 256'(tri_R10S), 256'(mk_tri(tbl[i].exp_idx, tbl[i].exp_req)));
      tick();
    end

    // Back-to-back from requester 0, latency 1
    for (int i = 0; i < 4; i++) begin
      rif.req_valid_H = 2'b01; halt_RnnnnL = 1; set_data(20 + i);
      tick();
      chk("b2b_valid", 256'(validTri_R10H), 256'(1));
      chk("b2b_tri", 256'(tri_R10S), 256'(mk_tri(20 + i, 0)));
    end
    rif.req_valid_H = 2'b00; tick();
    chk("b2b_end", 256'(validTri_R10H), 256'(0));

    // Stall with halt low for 5 cycles, then accept and regrant in the same cycle
    rif.req_valid_H = 2'b01; set_data(30); tick();
    rif.req_valid_H = 2'b11; halt_RnnnnL = 0;
    for (int i = 0; i < 5; i++) begin
      set_data(31 + i);
      #1 chk("stall_ready", 256'(rif.req_ready_H), 256'(0));
      tick();
      chk("stall_valid", 256'(validTri_R10H), 256'(1));
      chk("stall_tri", 256'(tri_R10S), 256'(mk_tri(30, 0)));
    end
    halt_RnnnnL = 1; set_data(36);
    #1 chk("resume_ready", 256'(rif.req_ready_H), 256'(2'b10));
    tick();
    chk("resume_tri", 256'(tri_R10S), 256'(mk_tri(36, 1)));

    // Config change: last accept coincides with drain entry
    rif.req_valid_H = 2'b00; cfg_valid_H = 1;
    cfg_screen_S[0] = 24'd1024; cfg_screen_S[1] = 24'd768; cfg_subSample_U = 4'b0100;
    tick();
    rif.req_valid_H = 2'b11; seen = 0; k = 0;
    while (k < 40 && !cfg_ready_H) begin
      if (k == 3) cfg_valid_H = 0;
      #1 seen |= (rif.req_ready_H != 2'b00);
      tick(); k++;
    end
    chk("drain_ticks", 256'(k), 256'(17));
    chk("drain_no_grant", 256'(seen), 256'(0));
    chk("cfg_screen_x", 256'(screen_RnnnnS[0]), 256'(24'd1024));
    chk("cfg_screen_y", 256'(screen_RnnnnS[1]), 256'(24'd768));
    chk("cfg_sub", 256'(subSample_RnnnnU), 256'(4'b0100));
    #1 chk("apply_ready", 256'(rif.req_ready_H), 256'(0));
    tick();
    chk("pulse_one", 256'(cfg_ready_H), 256'(0));
    #1 chk("run_ready", 256'(rif.req_ready_H), 256'(2'b01));
    tick();

    // Halt drop at drain count 10 restarts the idle count
    rif.req_valid_H = 2'b00; tick();
    cfg_valid_H = 1; tick();
    cfg_valid_H = 0; seen = 0;
    for (int i = 0; i < 10; i++) begin tick(); seen |= cfg_ready_H; end
    halt_RnnnnL = 0; tick(); seen |= cfg_ready_H;
    halt_RnnnnL = 1; k = 0;
    while (k < 40 && !cfg_ready_H) begin tick(); k++; end
    chk("drain_early_pulse", 256'(seen), 256'(0));
    chk("drain_restart_ticks", 256'(k), 256'(17));
    tick();

    // Reset in the middle of a drain abandons the config change
    rif.req_valid_H = 2'b11; cfg_valid_H = 1;
    cfg_screen_S[0] = 24'd640; cfg_screen_S[1] = 24'd480;
    for (int i = 0; i < 6; i++) tick();
    rst = 1; cfg_valid_H = 0;
    #1 chk("rst_drain_ready", 256'(rif.req_ready_H), 256'(0));
    tick();
    chk("rst_drain_valid", 256'(validTri_R10H), 256'(0));
    chk("rst_drain_screen", 256'(screen_RnnnnS), 256'(0));
    chk("rst_drain_sub", 256'(subSample_RnnnnU), 256'(0));
    chk("rst_drain_cfg_ready", 256'(cfg_ready_H), 256'(0));
    rst = 0; rif.req_valid_H = 2'b01;
    #1 chk("post_rst_ready", 256'(rif.req_ready_H), 256'(2'b01));
    seen = 0;
    for (int i = 0; i < 20; i++) begin tick(); seen |= cfg_ready_H; end
    chk("post_rst_no_pulse", 256'(seen), 256'(0));

    // Randomized traffic against the model
    hold = 0;
    for (int c = 0; c < 1500; c++) begin
      rst = ($urandom_range(0, 399) == 0);
      if (hold > 0) hold--;
      else if ($urandom_range(0, 59) == 0) hold = $urandom_range(1, 25);
      cfg_valid_H = (hold > 0);
      halt_RnnnnL = ($urandom_range(0, 15) != 0);
      rif.req_valid_H = 2'($urandom);
      for (int r = 0; r < 2; r++) begin
        for (int v = 0; v < VERTS; v++)
          for (int a = 0; a < AXIS; a++) rif.req_tri_S[r][v][a] = 24'($urandom);
        for (int q = 0; q < COLORS; q++) rif.req_color_U[r][q] = 24'($urandom);
      end
      cfg_screen_S[0] = 24'($urandom); cfg_screen_S[1] = 24'($urandom);
      cfg_subSample_U = 4'($urandom);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
